// File: rtl/genius_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | genius_pkg: state codes, size defaults and one-hot helper shared   |
// | by the genius sequence writer.               Revision: 1.0         |
// +------------------------------------------------------------------+
package genius_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_WAIT_PRESS   = 4'd1,
    ST_WAIT_RELEASE = 4'd2,
    ST_WRITE        = 4'd3,
    ST_DONE         = 4'd4
  } state_t;

  // Callers zero-extend their vector to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ram_16x4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_ram_16x4: single write port, registered read port with        |
// | read-old-data behaviour on same-address collision. Revision: 1.0   |
// +------------------------------------------------------------------+
module sync_ram_16x4 #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset so recorded contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/genius_seq_writer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | genius_seq_writer: records one-hot button presses into a RAM and   |
// | counts the length. Optional idle auto-finish: define               |
// | GENIUS_WRITER_TIMEOUT_EN.                    Revision: 1.0         |
// +------------------------------------------------------------------+
module genius_seq_writer
  import genius_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] botoes,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   length,
  output logic              writing,
  output logic              done,
  output logic              full,
  output logic              invalid_press,
  output logic              wr_pulse,
  output logic              timeout,
  output logic [3:0]        db_estado
);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W:0]     r_length;
  logic [ADDR_W:0]     w_len_inc;
  logic [DATA_W-1:0]   r_cap;
  logic                r_cap_valid;
  logic                r_full;
  logic                r_timeout;
  logic                r_stop_pending;
  logic                r_invalid;
  logic                w_press;
  logic                w_onehot;
  logic                w_last;
  logic                w_to_hit;
  logic                w_wr_en;
  logic                w_capture;
  logic                w_invalid;
  logic                w_to_fire;

  assign w_press   = (botoes != '0);
  assign w_onehot  = is_onehot(32'(botoes));
  assign w_len_inc = r_length + (ADDR_W+1)'(1);
  assign w_last    = (w_len_inc == (ADDR_W+1)'(DEPTH));

`ifdef GENIUS_WRITER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clock) begin
    if (reset || start || (r_state != ST_WAIT_PRESS)) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES - 1)) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_to_hit = (r_state == ST_WAIT_PRESS) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_capture = 1'b0;
    w_invalid = 1'b0;
    w_to_fire = 1'b0;
    if (start) begin
      w_next = ST_WAIT_PRESS;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: w_next = r_state;
        // A serviced stop wins over a press arriving in the same cycle.
        ST_WAIT_PRESS: begin
          if (stop || r_stop_pending) begin
            w_next = ST_DONE;
          end else if (w_press) begin
            w_next    = ST_WAIT_RELEASE;
            w_capture = w_onehot;
            w_invalid = !w_onehot;
          end else if (w_to_hit) begin
            w_next    = ST_DONE;
            w_to_fire = 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!w_press) begin
            w_next = r_cap_valid ? ST_WRITE : ST_WAIT_PRESS;
          end
        end
        ST_WRITE: begin
          w_wr_en = 1'b1;
          w_next  = w_last ? ST_DONE : ST_WAIT_PRESS;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_length       <= '0;
      r_cap          <= '0;
      r_cap_valid    <= 1'b0;
      r_full         <= 1'b0;
      r_timeout      <= 1'b0;
      r_stop_pending <= 1'b0;
      r_invalid      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_invalid <= w_invalid;
      if (start) begin
        r_length       <= '0;
        r_full         <= 1'b0;
        r_timeout      <= 1'b0;
        r_stop_pending <= 1'b0;
        r_cap_valid    <= 1'b0;
      end else begin
        if (w_capture) begin
          r_cap       <= botoes;
          r_cap_valid <= 1'b1;
        end else if (w_invalid) begin
          r_cap_valid <= 1'b0;
        end
        if (w_wr_en) begin
          r_length <= w_len_inc;
          if (w_last) begin
            r_full <= 1'b1;
          end
        end
        if (w_next == ST_DONE) begin
          r_stop_pending <= 1'b0;
        end else if (stop && ((r_state == ST_WAIT_RELEASE) || (r_state == ST_WRITE))) begin
          r_stop_pending <= 1'b1;
        end
        if (w_to_fire) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  sync_ram_16x4 #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clock),
    .rst     (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_length[ADDR_W-1:0]),
    .i_wdata (r_cap),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign length        = r_length;
  assign full          = r_full;
  assign timeout       = r_timeout;
  assign invalid_press = r_invalid;
  assign wr_pulse      = (r_state == ST_WRITE);
  assign done          = (r_state == ST_DONE);
  assign writing       = (r_state == ST_WAIT_PRESS) || (r_state == ST_WAIT_RELEASE) ||
                         (r_state == ST_WRITE);
  assign db_estado     = r_state;

endmodule
`default_nettype wire
